fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between three requesters:
  - display pixel fetch, which feeds px_data of the VGA timing controller;
  - a pixel-writer port (drawing engine or UART loader);
  - a CPU read-back port.
- Display fetch has absolute priority. Writer and reader share the remaining cycles round-robin.
- Sits between the frame-buffer RAM and the VGA timing controller, in the px_clk domain.

Parameters:
- ADDR_W, 17, frame-buffer word address width (320x240 = 76800 words fits).
- DATA_W, 12, pixel width (RGB444).

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_en  in  1  display needs a pixel; asserted 3 cycles ahead of the pixel's active cycle.
- fetch_addr  in  ADDR_W  display word address, valid with fetch_en.
- px_data  out  DATA_W  pixel to the VGA controller.
- wr_valid  in  1  writer request.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  DATA_W  writer data.
- wr_ready  out  1  writer granted this cycle.
- rd_valid  in  1  CPU read request.
- rd_addr  in  ADDR_W  CPU read address.
- rd_ready  out  1  reader granted this cycle.
- rd_rvalid  out  1  read data valid, one-cycle pulse.
- rd_rdata  out  DATA_W  read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; available 1 cycle after mem_en with mem_we=0.

Behaviour:
- Reset values:
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - px_data = 0; rd_rvalid = 0; rd_rdata = 0.
  - rr_last = reader, so the writer wins the first tie.
  - Source pipeline cleared to NONE.
- Cycle 0, arbitration (combinational):
  - fetch_en=1: grant DISP.
  - Otherwise, only wr_valid: grant WR. Only rd_valid: grant RD.
  - Both wr_valid and rd_valid: grant the one not equal to rr_last.
  - Nothing requested: NONE.
  - wr_ready = (grant==WR); rd_ready = (grant==RD).
  - A handshake completes when valid && ready.
  - Requesters hold valid, addr and data stable until ready is seen.
- Cycle 1: the grant is registered onto the mem_* outputs.
  - DISP or RD: mem_en=1, mem_we=0.
  - WR: mem_en=1, mem_we=1, mem_wdata = wr_data.
  - NONE: mem_en=0, mem_we=0; mem_addr holds its previous value.
- Cycle 2: the source tag travels in a 2-stage shift register alongside the command; mem_rdata is valid this cycle.
- Cycle 3: data is routed by tag.
  - DISP tag: px_data <= mem_rdata.
  - RD tag: rd_rdata <= mem_rdata and rd_rvalid=1 for exactly one cycle.
  - px_data holds its last value when the tag is not DISP.
- Latency:
  - fetch_en to px_data update: exactly 3 cycles.
  - rd handshake to rd_rvalid: exactly 3 cycles.
  - wr handshake to RAM write edge: 1 cycle.
- rr_last updates only on WR or RD grants; DISP grants leave it unchanged.
- Boundary conditions:
  - Continuous fetch_en (whole active line): wr_ready and rd_ready stay 0. Pending requests wait without loss and are served in blanking.
  - Write then read of the same address on consecutive grants: the read returns the new data, because the RAM write commits before the later read.
  - wr_valid and rd_valid held together: grants alternate every cycle, WR first after reset.
  - Requests never time out. No starvation is possible, because blanking is at least 160 cycles per line.
  - Reset asserted mid-operation: the in-flight pipeline is discarded, no rd_rvalid is emitted, and outputs go to their reset values asynchronously.
  - Address width: no wrap or range check. Address legality is the requester's responsibility.

Decomposition:
- Package fb_arb_pkg:
  - source encoding localparams SRC_NONE=2'd0, SRC_DISP=2'd1, SRC_WR=2'd2, SRC_RD=2'd3;
  - FETCH_LAT=3.
- Sub-module rr_arb2: 2-requester round-robin with rr_last state, producing one-hot grants; instantiated for WR/RD after display masking.

Test Plan:
- Reset: assert rst mid-stream -> all mem_*, px_data, rd_rvalid = 0 immediately; no stale rd_rvalid after release.
- Display priority:
  - stimulus: fetch_en=1 for 640 cycles with wr_valid=1 at addr 0x100;
  - required: wr_ready=0 throughout;
  - then fetch_en=0 -> wr_ready=1 in the first idle cycle and mem_we=1 with mem_addr=0x100 one cycle later.
- Display latency:
  - stimulus: fetch_en pulse with fetch_addr=5, RAM word 5 = 0xABC;
  - required: px_data = 0xABC exactly 3 cycles later and held afterwards.
- Round-robin:
  - stimulus: wr_valid and rd_valid held together for 4 cycles, fetch_en=0;
  - required grant order: WR, RD, WR, RD.
- Read-after-write:
  - stimulus: write 0x3F0 to addr 0x1234, then CPU read of 0x1234;
  - required: rd_rvalid pulses one cycle with rd_rdata = 0x3F0, 3 cycles after the rd handshake.
- Idle: no requests -> mem_en=0 and mem_addr stable for 100 cycles.

Source files
------------

// File: rtl/fb_port_arbiter_pkg.sv
// rtl/fb_port_arbiter_pkg.sv - source tags and pipeline depth shared by the frame-buffer arbiter
package fb_arb_pkg;

    typedef logic [1:0] src_t;

    localparam src_t SRC_NONE = 2'd0;
    localparam src_t SRC_DISP = 2'd1;
    localparam src_t SRC_WR   = 2'd2;
    localparam src_t SRC_RD   = 2'd3;

    // Cycles from a display fetch request to px_data update.
    localparam int FETCH_LAT = 3;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - requester and RAM signals of the frame-buffer arbiter
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);

    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] px_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rd_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  fetch_en, fetch_addr,
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        input  mem_rdata,
        output px_data, wr_ready, rd_ready, rd_rvalid, rd_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output fetch_en, fetch_addr,
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        output mem_rdata,
        input  px_data, wr_ready, rd_ready, rd_rvalid, rd_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_port_arbiter_rr_arb2.sv
// rtl/fb_port_arbiter_rr_arb2.sv - two-requester round-robin arbiter with one-hot grants
module rr_arb2 (
    input  logic px_clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // Set when requester b won the most recent grant; reset so a wins the first tie.
    logic last_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && (!req_b || last_b))
                gnt_a = 1'b1;
            else if (req_b)
                gnt_b = 1'b1;
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst)
            last_b <= 1'b1;
        else if (gnt_a)
            last_b <= 1'b0;
        else if (gnt_b)
            last_b <= 1'b1;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer RAM port arbiter: display fetch first, writer/reader round-robin
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              px_clk,
    input  logic              rst,
    fb_port_arbiter_if.master bus
);

    logic wr_gnt;
    logic rd_gnt;
    src_t grant;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] px_data_q;
    logic              rd_rvalid_q;
    logic [DATA_W-1:0] rd_rdata_q;

    // Tag travels with the command so returning RAM data can be routed.
    logic [FETCH_LAT-2:0][1:0] tag_q;
    src_t tag_out;

    rr_arb2 u_rr_arb2 (
        .px_clk (px_clk),
        .rst    (rst),
        .en     (!bus.fetch_en),
        .req_a  (bus.wr_valid),
        .req_b  (bus.rd_valid),
        .gnt_a  (wr_gnt),
        .gnt_b  (rd_gnt)
    );

    always_comb begin
        grant = SRC_NONE;
        if (bus.fetch_en)
            grant = SRC_DISP;
        else if (wr_gnt)
            grant = SRC_WR;
        else if (rd_gnt)
            grant = SRC_RD;
    end

    assign tag_out = tag_q[FETCH_LAT-2];

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            px_data_q   <= '0;
            rd_rvalid_q <= 1'b0;
            rd_rdata_q  <= '0;
            tag_q       <= '0;
        end else begin
            tag_q <= {tag_q, grant};

            case (grant)
                SRC_DISP: begin
                    mem_en_q   <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= bus.fetch_addr;
                end
                SRC_WR: begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= bus.wr_addr;
                    mem_wdata_q <= bus.wr_data;
                end
                SRC_RD: begin
                    mem_en_q   <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= bus.rd_addr;
                end
                default: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase

            if (tag_out == SRC_DISP)
                px_data_q <= bus.mem_rdata;

            rd_rvalid_q <= (tag_out == SRC_RD);
            if (tag_out == SRC_RD)
                rd_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.wr_ready  = wr_gnt;
    assign bus.rd_ready  = rd_gnt;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.px_data   = px_data_q;
    assign bus.rd_rvalid = rd_rvalid_q;
    assign bus.rd_rdata  = rd_rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - scoreboard bench for fb_port_arbiter with a synchronous RAM model
module tb_fb_port_arbiter;
    import fb_arb_pkg::*;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic px_clk = 1'b0;
    logic rst    = 1'b1;

    always #5 px_clk = ~px_clk;

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .px_clk (px_clk),
        .rst    (rst),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int              at;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t px_q[$];
    exp_t rd_q[$];

    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] px_model = '0;

    function automatic logic [DATA_W-1:0] pattern(input int i);
        return DATA_W'(i * 7 + 3);
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after mem_en.
    always @(posedge px_clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en) begin
            if (bus.mem_we)
                ram[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Scoreboard: handshakes push expectations, matured entries are checked.
    always @(negedge px_clk) begin
        logic exp_v;
        if (rst) begin
            px_q.delete();
            rd_q.delete();
            px_model = '0;
        end else begin
            if (bus.wr_valid && bus.wr_ready)
                shadow[bus.wr_addr] = bus.wr_data;
            if (bus.fetch_en)
                px_q.push_back('{cyc + FETCH_LAT, shadow[bus.fetch_addr]});
            if (bus.rd_valid && bus.rd_ready)
                rd_q.push_back('{cyc + FETCH_LAT, shadow[bus.rd_addr]});

            if (px_q.size() > 0 && px_q[0].at == cyc) begin
                px_model = px_q[0].data;
                void'(px_q.pop_front());
            end
            vectors++;
            if (bus.px_data !== px_model) begin
                miscompares++;
                $display("FAIL sb_px_data cyc=%0d got=%h exp=%h", cyc, bus.px_data, px_model);
            end

            exp_v = (rd_q.size() > 0 && rd_q[0].at == cyc);
            vectors++;
            if (bus.rd_rvalid !== exp_v) begin
                miscompares++;
                $display("FAIL sb_rd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rd_rvalid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (bus.rd_rdata !== rd_q[0].data) begin
                    miscompares++;
                    $display("FAIL sb_rd_rdata cyc=%0d got=%h exp=%h", cyc, bus.rd_rdata, rd_q[0].data);
                end
                void'(rd_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_addr    = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        logic [63:0] got;
        got = {bus.mem_en, bus.mem_we, 15'(bus.mem_addr), bus.mem_wdata,
               bus.px_data, bus.rd_rvalid, bus.rd_rdata};
        vectors++;
        if (got !== 64'd0) begin
            miscompares++;
            $display("FAIL %s outputs got=%h exp=0 (en=%b we=%b addr=%h px=%h rv=%b)", tag, got,
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.px_data, bus.rd_rvalid);
        end
        vectors++;
        if (bus.mem_addr !== '0) begin
            miscompares++;
            $display("FAIL %s mem_addr got=%h exp=0", tag, bus.mem_addr);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge px_clk);
        check_outputs_zero("reset_initial");
        @(posedge px_clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_wr;
        logic hs_w, hs_r;
        tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 17'h20; bus.wr_data = 12'h111;
        bus.rd_valid = 1'b1; bus.rd_addr = 17'h30;
        for (int k = 0; k < 4; k++) begin
            @(negedge px_clk);
            exp_wr = (k % 2 == 0);
            vectors++;
            if (bus.wr_ready !== exp_wr || bus.rd_ready !== !exp_wr) begin
                miscompares++;
                $display("FAIL rr_grant k=%0d got wr=%b rd=%b exp wr=%b rd=%b",
                         k, bus.wr_ready, bus.rd_ready, exp_wr, !exp_wr);
            end
            hs_w = bus.wr_ready;
            hs_r = bus.rd_ready;
            tick();
            if (hs_w) begin
                bus.wr_addr = bus.wr_addr + 17'd1;
                bus.wr_data = bus.wr_data + 12'h011;
            end
            if (hs_r)
                bus.rd_addr = bus.rd_addr + 17'd1;
        end
        idle_inputs();
        repeat (5) tick();
    endtask

    task automatic test_display_priority();
        for (int i = 0; i < 640; i++) begin
            tick();
            bus.fetch_en   = 1'b1;
            bus.fetch_addr = ADDR_W'(i);
            bus.wr_valid   = 1'b1;
            bus.wr_addr    = 17'h100;
            bus.wr_data    = 12'h7E1;
            @(negedge px_clk);
            vectors++;
            if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL disp_block i=%0d got wr_ready=%b rd_ready=%b exp 0", i,
                         bus.wr_ready, bus.rd_ready);
            end
        end
        tick();
        bus.fetch_en = 1'b0;
        @(negedge px_clk);
        vectors++;
        if (bus.wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL disp_release_wr_ready got=%b exp=1", bus.wr_ready);
        end
        tick();
        bus.wr_valid = 1'b0;
        @(negedge px_clk);
        vectors++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h100 ||
            bus.mem_wdata !== 12'h7E1) begin
            miscompares++;
            $display("FAIL disp_release_write got en=%b we=%b addr=%h wdata=%h exp 1 1 00100 7e1",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        idle_inputs();
        repeat (5) tick();
    endtask

    task automatic test_display_latency();
        logic [DATA_W-1:0] prev;
        prev = shadow[639];
        ram[5]    = 12'hABC;
        shadow[5] = 12'hABC;
        tick();
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 17'd5;
        tick();
        bus.fetch_en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge px_clk);
            vectors++;
            if (k < FETCH_LAT) begin
                if (bus.px_data !== prev) begin
                    miscompares++;
                    $display("FAIL disp_lat_early k=%0d got=%h exp=%h", k, bus.px_data, prev);
                end
            end else if (bus.px_data !== 12'hABC) begin
                miscompares++;
                $display("FAIL disp_lat_hold k=%0d got=%h exp=abc", k, bus.px_data);
            end
            if (k < 7) tick();
        end
    endtask

    task automatic test_read_after_write();
        int  hs_cyc;
        int  n;
        bit  seen;
        tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 17'h1234; bus.wr_data = 12'h3F0;
        n = 0;
        @(negedge px_clk);
        while (bus.wr_ready !== 1'b1 && n < 20) begin
            tick();
            @(negedge px_clk);
            n++;
        end
        vectors++;
        if (bus.wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_wr_grant got=%b exp=1 (timeout)", bus.wr_ready);
        end
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 17'h1234;
        @(negedge px_clk);
        hs_cyc = cyc;
        vectors++;
        if (bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_rd_grant got=%b exp=1", bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge px_clk);
            if (bus.rd_rvalid === 1'b1) begin
                seen = 1;
                vectors++;
                if (cyc - hs_cyc !== FETCH_LAT || bus.rd_rdata !== 12'h3F0) begin
                    miscompares++;
                    $display("FAIL raw_rdata got lat=%0d data=%h exp lat=3 data=3f0",
                             cyc - hs_cyc, bus.rd_rdata);
                end
            end else begin
                tick();
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL raw_rvalid_timeout got=none exp=pulse");
        end
        tick();
        @(negedge px_clk);
        vectors++;
        if (bus.rd_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_rvalid_width got=%b exp=0", bus.rd_rvalid);
        end
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int k = 0; k < 100; k++) begin
            tick();
            @(negedge px_clk);
            vectors++;
            if (bus.mem_en !== 1'b0 || bus.mem_addr !== 17'h1234) begin
                miscompares++;
                $display("FAIL idle k=%0d got en=%b addr=%h exp en=0 addr=01234", k,
                         bus.mem_en, bus.mem_addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.rd_valid = 1'b1; bus.rd_addr = 17'h55;
        @(negedge px_clk);
        vectors++;
        if (bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_rd_grant got=%b exp=1", bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset_mid");
        repeat (3) @(posedge px_clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge px_clk);
            vectors++;
            if (bus.rd_rvalid !== 1'b0 || bus.px_data !== '0) begin
                miscompares++;
                $display("FAIL rstmid_stale k=%0d got rvalid=%b px=%h exp 0 000", k,
                         bus.rd_rvalid, bus.px_data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = pattern(i);
            shadow[i] = pattern(i);
        end
        bus.mem_rdata = '0;
        test_reset();
        test_round_robin();
        test_display_priority();
        test_display_latency();
        test_read_after_write();
        test_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
